ecl_dialer: RTL and testbench
=============================

# ecl_dialer

Automatic code-entry sequencer for the electronic combination lock. On a start request it clears the lock, then replays a stored combination as one-cycle, one-hot button presses on the lock's `but_0`/`but_1` inputs, spaced by idle gap cycles. It then waits a bounded time for the lock's UNLOCK output and reports pass/fail. It sits beside the lock as its input-side driver, used for self-test and automated unlock.

## Interface
- `CODE_LEN`, default 5: number of presses in a combination; must be ≥ 1.
- `GAP_CYCLES`, default 1: idle cycles (both buttons low) after every press; may be 0.
- `TIMEOUT_CYCLES`, default 4: maximum WAIT cycles for UNLOCK; must be ≥ 1.
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `START` in 1: dial request; honoured only in IDLE.
- `CODE_IN` in `CODE_LEN`: combination, sampled on the accepted START edge.
  - Bit `CODE_LEN-1` is pressed first.
  - Bit value 0 presses `but_0`; bit value 1 presses `but_1`.
- `UNLOCK` in 1: lock status, sampled only in WAIT.
- `LOCK_RESET_N` out 1: active-low lock clear, low for exactly one cycle per dial.
- `but_0` out 1: press of button 0.
- `but_1` out 1: press of button 1.
- `BUSY` out 1: high in every non-IDLE state.
- `DONE` out 1: one-cycle completion pulse.
- `PASS` out 1: result of the last dial; valid from DONE until the next accepted START.

## Operation
- All outputs come straight from flops, so there are no glitches on lock inputs.
- Reset values:
  - `LOCK_RESET_N`=1.
  - `but_0`=`but_1`=0.
  - `BUSY`=0, `DONE`=0, `PASS`=0.
  - State IDLE; shift register and counters cleared.
- States and transitions:
  - IDLE: wait for START. On START=1, load `CODE_IN` into the shift register, clear `PASS` → CLR.
  - CLR: `LOCK_RESET_N`=0 for one cycle → PRESS.
  - PRESS: drive exactly one button for one cycle, chosen by the shift-register MSB. Shift left and decrement the remaining-press count. Next state:
    - `GAP_CYCLES`>0 → GAP.
    - otherwise, presses remaining → PRESS.
    - otherwise → WAIT.
  - GAP: both buttons low for `GAP_CYCLES` cycles, then → PRESS if presses remain, else → WAIT.
  - WAIT: both buttons low.
    - `UNLOCK`=1 sampled → REPORT with `PASS`=1.
    - After `TIMEOUT_CYCLES` WAIT cycles with no UNLOCK → REPORT with `PASS`=0.
  - REPORT: `DONE`=1 for one cycle → IDLE.
- The two buttons are never high together, and a press never lasts more than one cycle. This avoids multi-counting in the lock, which advances once per cycle while exactly one button is high.
- START outside IDLE is ignored, with no queuing. START held high re-triggers a new dial from IDLE after REPORT.
- UNLOCK outside WAIT is ignored.
- The dialer never relocks a successfully unlocked lock; the next dial's CLR does.
- RESET mid-dial: outputs go to their reset values immediately (asynchronously) and any in-flight press is cut.
- Counter widths:
  - Gap counter: `$clog2(GAP_CYCLES+1)`.
  - Timeout counter: `$clog2(TIMEOUT_CYCLES+1)`.
  - Press counter: `$clog2(CODE_LEN+1)`.
  - No counter wraps; each is reloaded on state entry.

## Timing
- Cycle n is the interval after rising edge n; START is high in cycle 0.
- CLR is cycle 1. Press k (k = 0..CODE_LEN-1) occurs in cycle 2 + k·(1+GAP_CYCLES).
- WAIT is entered in cycle 2 + CODE_LEN·(1+GAP_CYCLES). With defaults, presses fall in cycles 2, 4, 6, 8, 10 and WAIT starts in cycle 12.
- The lock registers the last press at edge 11, so its Moore UNLOCK is high from cycle 11. The dialer sees it in cycle 12, giving DONE/PASS=1 in cycle 13 and BUSY low from cycle 14.
- Failure latency: DONE occurs in cycle (WAIT start + TIMEOUT_CYCLES), which is cycle 16 with defaults.
- `LOCK_RESET_N` deasserts at edge 2, one full cycle before the lock samples the first press at edge 3.

## Structure
- Shared package `ecl_pkg`:
  - state typedef `ecl_dial_state_t` (IDLE, CLR, PRESS, GAP, WAIT, REPORT);
  - constant `ECL_DEFAULT_CODE` = 5'b01011;
  - constant `ECL_DEFAULT_CODE_LEN` = 5.
- One sub-module, `ecl_cycle_counter`: a loadable down-counter with a zero flag, parameterised by width. It is instantiated twice, once for the gap count and once for the timeout count.
- The FSM, shift register and output flops live in `ecl_dialer`.

## Test plan
- Correct code, full system: dialer with defaults driving the real lock, `CODE_IN`=5'b01011, START pulse in cycle 0.
  - Required: `LOCK_RESET_N`=0 only in cycle 1.
  - Required presses: `but_0` in cycles 2 and 6; `but_1` in cycles 4, 8 and 10.
  - Required result: DONE=1 and PASS=1 in cycle 13; BUSY high in cycles 1–13.
- Wrong code: `CODE_IN`=5'b01010 → the lock never unlocks; DONE=1 with PASS=0 in cycle 16.
- Timeout with stuck UNLOCK: UNLOCK tied 0, `GAP_CYCLES`=0, `TIMEOUT_CYCLES`=3.
  - Required: presses in cycles 2–6; WAIT in cycles 7–9; DONE in cycle 10 with PASS=0.
- Ignored START: START pulsed again in cycles 5 and 9 during a dial → no change in button sequence or DONE timing; exactly one DONE.
- Reset mid-dial: RESET asserted during cycle 4 (a press) → `but_1` falls immediately; all outputs at reset values; after release, a new START gives the full default sequence with PASS=1.
- Back-to-back dials: START held high → second dial's CLR occurs in cycle 15 (the cycle after REPORT returns to IDLE in cycle 14); the lock relocks, then unlocks again; PASS clears at the second accepted START.

Source files
------------

// File: rtl/ecl_pkg.sv
// Shared definitions for the electronic combination lock dialer: FSM state
// encoding, default combination and a counter-width helper.
package ecl_pkg;

  typedef logic [2:0] ecl_dial_state_t;

  localparam ecl_dial_state_t ST_IDLE   = 3'd0;
  localparam ecl_dial_state_t ST_CLR    = 3'd1;
  localparam ecl_dial_state_t ST_PRESS  = 3'd2;
  localparam ecl_dial_state_t ST_GAP    = 3'd3;
  localparam ecl_dial_state_t ST_WAIT   = 3'd4;
  localparam ecl_dial_state_t ST_REPORT = 3'd5;

  localparam logic [4:0] ECL_DEFAULT_CODE     = 5'b01011;
  localparam int         ECL_DEFAULT_CODE_LEN = 5;

  // Bits needed to hold 0..max_val; never less than one so that a counter
  // whose range collapses to zero still has a legal declaration.
  function automatic int ecl_cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/ecl_cycle_counter.sv
// Loadable down-counter with a zero flag. Loading takes priority over
// counting; the count sticks at zero instead of wrapping.
module ecl_cycle_counter #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Reload on state entry, otherwise count down while enabled and hold at zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/ecl_dialer.sv
// Automatic code-entry sequencer for the combination lock: clears the lock,
// replays a stored combination as one-cycle one-hot button presses separated
// by idle gaps, then waits a bounded time for UNLOCK and reports pass/fail.
// Every output is a flop so the lock never sees a glitch or a double press.
module ecl_dialer
  import ecl_pkg::*;
#(
  parameter int CODE_LEN       = ECL_DEFAULT_CODE_LEN,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [CODE_LEN-1:0] CODE_IN,
  input  logic                UNLOCK,
  output logic                LOCK_RESET_N,
  output logic                but_0,
  output logic                but_1,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS
);

  localparam int PRESS_W  = ecl_cnt_width(CODE_LEN);
  localparam int GAP_W    = ecl_cnt_width(GAP_CYCLES);
  localparam int TO_W     = ecl_cnt_width(TIMEOUT_CYCLES);
  // Counters hold "cycles left after this one", hence the minus one.
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam int TO_LOAD  = TIMEOUT_CYCLES - 1;
  localparam bit HAS_GAP  = (GAP_CYCLES > 0);

  ecl_dial_state_t     state_r;
  ecl_dial_state_t     state_next_s;
  logic [CODE_LEN-1:0] shift_r;
  logic [PRESS_W-1:0]  press_cnt_r;
  logic                press_left_s;
  logic                start_acc_s;
  logic                gap_load_s;
  logic                gap_dec_s;
  logic                gap_zero_s;
  logic                to_load_s;
  logic                to_dec_s;
  logic                to_zero_s;
  logic                lock_reset_n_r;
  logic                but_0_r;
  logic                but_1_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;

  assign start_acc_s  = (state_r == ST_IDLE) && START;
  assign press_left_s = (press_cnt_r != '0);

  assign gap_load_s = (state_next_s == ST_GAP) && (state_r != ST_GAP);
  assign gap_dec_s  = (state_r == ST_GAP);
  assign to_load_s  = (state_next_s == ST_WAIT) && (state_r != ST_WAIT);
  assign to_dec_s   = (state_r == ST_WAIT);

  ecl_cycle_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (gap_load_s),
    .load_value (GAP_W'(GAP_LOAD)),
    .dec        (gap_dec_s),
    .zero       (gap_zero_s)
  );

  ecl_cycle_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (to_load_s),
    .load_value (TO_W'(TO_LOAD)),
    .dec        (to_dec_s),
    .zero       (to_zero_s)
  );

  // Next-state decode for the dial sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_next_s = ST_CLR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        state_next_s = ST_PRESS;
      end
      ST_PRESS: begin
        if (HAS_GAP) begin
          state_next_s = ST_GAP;
        end else if (press_left_s) begin
          state_next_s = ST_PRESS;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (!gap_zero_s) begin
          state_next_s = ST_GAP;
        end else if (press_left_s) begin
          state_next_s = ST_PRESS;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (UNLOCK || to_zero_s) begin
          state_next_s = ST_REPORT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_REPORT: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Combination shift register and remaining-press count; both advance on
  // every edge that enters PRESS, so the button flop sees the pre-shift MSB.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift_r     <= '0;
      press_cnt_r <= '0;
    end else if (start_acc_s) begin
      shift_r     <= CODE_IN;
      press_cnt_r <= PRESS_W'(CODE_LEN);
    end else if (state_next_s == ST_PRESS) begin
      shift_r     <= shift_r << 1'b1;
      press_cnt_r <= press_cnt_r - PRESS_W'(1);
    end else begin
      shift_r     <= shift_r;
      press_cnt_r <= press_cnt_r;
    end
  end

  // Output flops, decoded from the state being entered so each output is
  // aligned with its state and comes straight from a register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_reset_n_r <= 1'b1;
      but_0_r        <= 1'b0;
      but_1_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      lock_reset_n_r <= (state_next_s != ST_CLR);
      but_0_r        <= (state_next_s == ST_PRESS) && !shift_r[CODE_LEN-1];
      but_1_r        <= (state_next_s == ST_PRESS) &&  shift_r[CODE_LEN-1];
      busy_r         <= (state_next_s != ST_IDLE);
      done_r         <= (state_next_s == ST_REPORT);
    end
  end

  // Result flag: cleared by an accepted START, decided on leaving WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pass_r <= 1'b0;
    end else if (start_acc_s) begin
      pass_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && UNLOCK) begin
      pass_r <= 1'b1;
    end else if ((state_r == ST_WAIT) && to_zero_s) begin
      pass_r <= 1'b0;
    end else begin
      pass_r <= pass_r;
    end
  end

  assign LOCK_RESET_N = lock_reset_n_r;
  assign but_0        = but_0_r;
  assign but_1        = but_1_r;
  assign BUSY         = busy_r;
  assign DONE         = done_r;
  assign PASS         = pass_r;

endmodule

// File: tb/tb_ecl_dialer.sv
// Directed bench for ecl_dialer. dut_a (defaults) drives a behavioural lock
// that stores ECL_DEFAULT_CODE; dut_b (no gap, timeout 3) has UNLOCK tied low.
// Each scenario records one bit per cycle per output and compares the traces
// with hand-computed cycle masks (bit n = cycle n after the START edge).
module tb_ecl_dialer;
  import ecl_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start_a, start_b;
  logic [4:0] code_a, code_b;
  logic       unlock_a;
  logic       lrn_a, b0_a, b1_a, busy_a, done_a, pass_a;
  logic       lrn_b, b0_b, b1_b, busy_b, done_b, pass_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] r_lrn_low, r_b0, r_b1, r_busy, r_done, r_pass, r_unl;

  always #5 CLK = ~CLK;

  ecl_dialer dut_a (
    .CLK(CLK), .RESET(RESET), .START(start_a), .CODE_IN(code_a), .UNLOCK(unlock_a),
    .LOCK_RESET_N(lrn_a), .but_0(b0_a), .but_1(b1_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a)
  );

  ecl_dialer #(.CODE_LEN(5), .GAP_CYCLES(0), .TIMEOUT_CYCLES(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .START(start_b), .CODE_IN(code_b), .UNLOCK(1'b0),
    .LOCK_RESET_N(lrn_b), .but_0(b0_b), .but_1(b1_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b)
  );

  // Behavioural lock: one step per cycle with exactly one button high,
  // cleared by LOCK_RESET_N low, Moore UNLOCK after five matching presses.
  logic [4:0] lk_sh;
  logic [2:0] lk_cnt;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lk_sh  <= 5'd0;
      lk_cnt <= 3'd0;
    end else if (!lrn_a) begin
      lk_sh  <= 5'd0;
      lk_cnt <= 3'd0;
    end else if (b0_a ^ b1_a) begin
      lk_sh <= {lk_sh[3:0], b1_a};
      if (lk_cnt != 3'd5) lk_cnt <= lk_cnt + 3'd1;
    end
  end
  assign unlock_a = (lk_cnt == 3'd5) && (lk_sh == ECL_DEFAULT_CODE);

  // Entered just after a rising edge (cycle 0); drives START per pat and
  // records the chosen DUT's outputs mid-cycle; leaves just after edge ncyc.
  task automatic run_dial(input bit sel, input logic [4:0] code, input logic [63:0] pat, input int ncyc);
    r_lrn_low = '0; r_b0 = '0; r_b1 = '0; r_busy = '0; r_done = '0; r_pass = '0; r_unl = '0;
    if (sel) code_b = code; else code_a = code;
    for (int c = 0; c < ncyc; c++) begin
      if (sel) start_b = pat[c]; else start_a = pat[c];
      @(negedge CLK);
      r_lrn_low[c] = sel ? !lrn_b  : !lrn_a;
      r_b0[c]      = sel ? b0_b    : b0_a;
      r_b1[c]      = sel ? b1_b    : b1_a;
      r_busy[c]    = sel ? busy_b  : busy_a;
      r_done[c]    = sel ? done_b  : done_a;
      r_pass[c]    = sel ? pass_b  : pass_a;
      r_unl[c]     = unlock_a;
      @(posedge CLK); #1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; start_a = 1'b0; start_b = 1'b0;
    code_a = 5'd0; code_b = 5'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if ({lrn_a, b0_a, b1_a, busy_a, done_a, pass_a} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_a: got %b expected %b", {lrn_a, b0_a, b1_a, busy_a, done_a, pass_a}, 6'b100000); end
    n_checks++; if ({lrn_b, b0_b, b1_b, busy_b, done_b, pass_b} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_b: got %b expected %b", {lrn_b, b0_b, b1_b, busy_b, done_b, pass_b}, 6'b100000); end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_correct_code();
    run_dial(1'b0, 5'b01011, 64'h1, 16);
    n_checks++; if (r_lrn_low !== 64'h2) begin n_fail++; $display("FAIL correct_lrn: got %h expected %h", r_lrn_low, 64'h2); end
    n_checks++; if (r_b0 !== 64'h44) begin n_fail++; $display("FAIL correct_b0: got %h expected %h", r_b0, 64'h44); end
    n_checks++; if (r_b1 !== 64'h510) begin n_fail++; $display("FAIL correct_b1: got %h expected %h", r_b1, 64'h510); end
    n_checks++; if (r_busy !== 64'h3FFE) begin n_fail++; $display("FAIL correct_busy: got %h expected %h", r_busy, 64'h3FFE); end
    n_checks++; if (r_done !== 64'h2000) begin n_fail++; $display("FAIL correct_done: got %h expected %h", r_done, 64'h2000); end
    n_checks++; if (r_pass !== 64'hE000) begin n_fail++; $display("FAIL correct_pass: got %h expected %h", r_pass, 64'hE000); end
    n_checks++; if (r_unl !== 64'hF800) begin n_fail++; $display("FAIL correct_unlock: got %h expected %h", r_unl, 64'hF800); end
    n_checks++; if ((r_b0 & r_b1) !== 64'h0) begin n_fail++; $display("FAIL correct_onehot: got %h expected %h", r_b0 & r_b1, 64'h0); end
  endtask

  task automatic test_wrong_code();
    // Cycle 0 still shows the previous PASS=1 and the lock still open.
    run_dial(1'b0, 5'b01010, 64'h1, 18);
    n_checks++; if (r_lrn_low !== 64'h2) begin n_fail++; $display("FAIL wrong_lrn: got %h expected %h", r_lrn_low, 64'h2); end
    n_checks++; if (r_b0 !== 64'h444) begin n_fail++; $display("FAIL wrong_b0: got %h expected %h", r_b0, 64'h444); end
    n_checks++; if (r_b1 !== 64'h110) begin n_fail++; $display("FAIL wrong_b1: got %h expected %h", r_b1, 64'h110); end
    n_checks++; if (r_busy !== 64'h1FFFE) begin n_fail++; $display("FAIL wrong_busy: got %h expected %h", r_busy, 64'h1FFFE); end
    n_checks++; if (r_done !== 64'h10000) begin n_fail++; $display("FAIL wrong_done: got %h expected %h", r_done, 64'h10000); end
    n_checks++; if (r_pass !== 64'h1) begin n_fail++; $display("FAIL wrong_pass: got %h expected %h", r_pass, 64'h1); end
    n_checks++; if (r_unl !== 64'h3) begin n_fail++; $display("FAIL wrong_unlock: got %h expected %h", r_unl, 64'h3); end
  endtask

  task automatic test_timeout();
    run_dial(1'b1, 5'b10110, 64'h1, 12);
    n_checks++; if (r_lrn_low !== 64'h2) begin n_fail++; $display("FAIL timeout_lrn: got %h expected %h", r_lrn_low, 64'h2); end
    n_checks++; if (r_b0 !== 64'h48) begin n_fail++; $display("FAIL timeout_b0: got %h expected %h", r_b0, 64'h48); end
    n_checks++; if (r_b1 !== 64'h34) begin n_fail++; $display("FAIL timeout_b1: got %h expected %h", r_b1, 64'h34); end
    n_checks++; if (r_busy !== 64'h7FE) begin n_fail++; $display("FAIL timeout_busy: got %h expected %h", r_busy, 64'h7FE); end
    n_checks++; if (r_done !== 64'h400) begin n_fail++; $display("FAIL timeout_done: got %h expected %h", r_done, 64'h400); end
    n_checks++; if (r_pass !== 64'h0) begin n_fail++; $display("FAIL timeout_pass: got %h expected %h", r_pass, 64'h0); end
  endtask

  task automatic test_ignored_start();
    run_dial(1'b0, 5'b01011, 64'h221, 20);
    n_checks++; if (r_lrn_low !== 64'h2) begin n_fail++; $display("FAIL ignored_lrn: got %h expected %h", r_lrn_low, 64'h2); end
    n_checks++; if (r_b0 !== 64'h44) begin n_fail++; $display("FAIL ignored_b0: got %h expected %h", r_b0, 64'h44); end
    n_checks++; if (r_b1 !== 64'h510) begin n_fail++; $display("FAIL ignored_b1: got %h expected %h", r_b1, 64'h510); end
    n_checks++; if (r_busy !== 64'h3FFE) begin n_fail++; $display("FAIL ignored_busy: got %h expected %h", r_busy, 64'h3FFE); end
    n_checks++; if (r_done !== 64'h2000) begin n_fail++; $display("FAIL ignored_done: got %h expected %h", r_done, 64'h2000); end
    n_checks++; if ($countones(r_done) != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d expected %0d", $countones(r_done), 1); end
    n_checks++; if (r_pass !== 64'hFE000) begin n_fail++; $display("FAIL ignored_pass: got %h expected %h", r_pass, 64'hFE000); end
  endtask

  task automatic test_reset_mid_dial();
    code_a  = ECL_DEFAULT_CODE;
    start_a = 1'b1;                      // cycle 0
    @(posedge CLK); #1; start_a = 1'b0;  // cycle 1
    repeat (3) begin @(posedge CLK); #1; end  // cycle 4: press of but_1
    @(negedge CLK);
    n_checks++; if (b1_a !== 1'b1) begin n_fail++; $display("FAIL midreset_press: got %b expected %b", b1_a, 1'b1); end
    #1 RESET = 1'b1;
    #1;
    n_checks++; if ({lrn_a, b0_a, b1_a, busy_a, done_a, pass_a} !== 6'b100000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected %b", {lrn_a, b0_a, b1_a, busy_a, done_a, pass_a}, 6'b100000); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    run_dial(1'b0, ECL_DEFAULT_CODE, 64'h1, 16);
    n_checks++; if (r_b0 !== 64'h44) begin n_fail++; $display("FAIL midreset_b0: got %h expected %h", r_b0, 64'h44); end
    n_checks++; if (r_b1 !== 64'h510) begin n_fail++; $display("FAIL midreset_b1: got %h expected %h", r_b1, 64'h510); end
    n_checks++; if (r_done !== 64'h2000) begin n_fail++; $display("FAIL midreset_done: got %h expected %h", r_done, 64'h2000); end
    n_checks++; if (r_pass !== 64'hE000) begin n_fail++; $display("FAIL midreset_pass: got %h expected %h", r_pass, 64'hE000); end
  endtask

  task automatic test_back_to_back();
    // START held for cycles 0..20: second CLR in cycle 15, second REPORT in 27.
    run_dial(1'b0, ECL_DEFAULT_CODE, 64'h1FFFFF, 32);
    n_checks++; if (r_lrn_low !== 64'h8002) begin n_fail++; $display("FAIL b2b_lrn: got %h expected %h", r_lrn_low, 64'h8002); end
    n_checks++; if (r_b0 !== 64'h110044) begin n_fail++; $display("FAIL b2b_b0: got %h expected %h", r_b0, 64'h110044); end
    n_checks++; if (r_b1 !== 64'h1440510) begin n_fail++; $display("FAIL b2b_b1: got %h expected %h", r_b1, 64'h1440510); end
    n_checks++; if (r_busy !== 64'h0FFFBFFE) begin n_fail++; $display("FAIL b2b_busy: got %h expected %h", r_busy, 64'h0FFFBFFE); end
    n_checks++; if (r_done !== 64'h8002000) begin n_fail++; $display("FAIL b2b_done: got %h expected %h", r_done, 64'h8002000); end
    n_checks++; if (r_pass !== 64'hF8006001) begin n_fail++; $display("FAIL b2b_pass: got %h expected %h", r_pass, 64'hF8006001); end
    n_checks++; if (r_unl !== 64'hFE00F803) begin n_fail++; $display("FAIL b2b_unlock: got %h expected %h", r_unl, 64'hFE00F803); end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_timeout();
    test_ignored_start();
    test_reset_mid_dial();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
